// File: rtl/collision_scanner.sv
// collision_scanner: streams the scene map once per start request and derives obstruction,
// hazard, end-of-level and coin-pickup results for the character. Optional macro: COIN_FIFO_EN.
module collision_scanner #(
   parameter int SCENE_W_BLK = 20,
   parameter int SCENE_H_BLK = 15,
   parameter int BLK_PX      = 20,
   parameter int CHAR_W_PX   = 20,
   parameter int CHAR_H_PX   = 40,
   parameter int MEM_LAT     = 1,
   parameter int ADDR_W      = 9,
   parameter int POS_W       = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play_state,
   input  logic              start,
   input  logic [POS_W-1:0]  char_x,
   input  logic [POS_W-1:0]  char_y,
   input  logic [1:0]        blk_type,
   output logic [ADDR_W-1:0] blk_addr,
   output logic              busy,
   output logic              done,
   output logic              obs_up,
   output logic              obs_right,
   output logic              obs_down,
   output logic              obs_left,
   output logic              die,
   output logic              reach_end,
   output logic [7:0]        score,
   output logic              coin_valid,
   output logic [ADDR_W-1:0] coin_addr,
   input  logic              coin_ack
);

   localparam int W      = POS_W + 2;
   localparam int CW     = (SCENE_W_BLK > 1) ? $clog2(SCENE_W_BLK) : 1;
   localparam int RW     = (SCENE_H_BLK > 1) ? $clog2(SCENE_H_BLK) : 1;
   localparam int PIPE_D = (MEM_LAT > 0) ? MEM_LAT : 1;

   localparam logic [W-1:0]  BLK_W   = W'(BLK_PX);
   localparam logic [W-1:0]  CHR_W   = W'(CHAR_W_PX);
   localparam logic [W-1:0]  CHR_H   = W'(CHAR_H_PX);
   localparam logic [W-1:0]  HALF_W  = W'(CHAR_W_PX / 2);
   localparam logic [W-1:0]  SCN_W   = W'(SCENE_W_BLK * BLK_PX);
   localparam logic [W-1:0]  SCN_H   = W'(SCENE_H_BLK * BLK_PX);
   localparam logic [CW-1:0] COL_END = CW'(SCENE_W_BLK - 1);
   localparam logic [RW-1:0] ROW_END = RW'(SCENE_H_BLK - 1);
   localparam logic [1:0]    DRAIN_END = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

   localparam logic [1:0] T_BLOCK  = 2'd1;
   localparam logic [1:0] T_CACTUS = 2'd2;
   localparam logic [1:0] T_COIN   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              busy_c, accept_c, issue_c, publish_c, last_c;
   logic [1:0]        drain_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [POS_W-1:0]  cx_q, cy_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state elements use non-blocking assignments so every register samples
      // pre-edge values; blocking here would make results depend on block ordering.
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   assign last_c = (col_q == COL_END) && (row_q == ROW_END);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && play_state) state_d = S_SCAN;
         S_SCAN:  if (last_c) state_d = (MEM_LAT == 0) ? S_DONE : S_DRAIN;
         S_DRAIN: if (drain_q == DRAIN_END) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (!play_state) state_d = S_IDLE;
   end

   always_comb begin
      busy_c    = 1'b0;
      accept_c  = 1'b0;
      issue_c   = 1'b0;
      publish_c = 1'b0;
      case (state_q)
         S_IDLE:  accept_c = start && play_state;
         S_SCAN:  begin busy_c = 1'b1; issue_c = 1'b1; end
         S_DRAIN: busy_c = 1'b1;
         S_DONE:  publish_c = play_state;
         default: ;
      endcase
   end

   assign busy = busy_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    drain_q <= '0;
      else if (state_q == S_DRAIN) drain_q <= drain_q + 2'd1;
      else                         drain_q <= '0;
   end

   // ---------------------------------------------------- address generator
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         cx_q   <= '0;
         cy_q   <= '0;
      end else if (accept_c) begin
         addr_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         cx_q   <= char_x;
         cy_q   <= char_y;
      end else if (issue_c && !last_c) begin
         addr_q <= addr_q + ADDR_W'(1);
         if (col_q == COL_END) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   assign blk_addr = addr_q;

   // ------------------------------------- delay pipeline pairing data with tile
   logic [PIPE_D-1:0] pv_q;
   logic [CW-1:0]     pcol_q  [PIPE_D];
   logic [RW-1:0]     prow_q  [PIPE_D];
   logic [ADDR_W-1:0] paddr_q [PIPE_D];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv_q <= '0;
      end else begin
         pv_q[0] <= issue_c;
         for (int i = 1; i < PIPE_D; i++) pv_q[i] <= pv_q[i-1] && (state_q != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      pcol_q[0]  <= col_q;
      prow_q[0]  <= row_q;
      paddr_q[0] <= addr_q;
      for (int i = 1; i < PIPE_D; i++) begin
         pcol_q[i]  <= pcol_q[i-1];
         prow_q[i]  <= prow_q[i-1];
         paddr_q[i] <= paddr_q[i-1];
      end
   end

   logic              tap_v;
   logic [CW-1:0]     tap_col;
   logic [RW-1:0]     tap_row;
   logic [ADDR_W-1:0] tap_addr;

   generate
      if (MEM_LAT == 0) begin : g_lat0
         assign tap_v    = issue_c;
         assign tap_col  = col_q;
         assign tap_row  = row_q;
         assign tap_addr = addr_q;
      end else begin : g_latn
         assign tap_v    = pv_q[MEM_LAT-1];
         assign tap_col  = pcol_q[MEM_LAT-1];
         assign tap_row  = prow_q[MEM_LAT-1];
         assign tap_addr = paddr_q[MEM_LAT-1];
      end
   endgenerate

   // ----------------------------------------------------------- geometry
   logic [W-1:0] cx, cy, cr, cb, tx, ty, tr, tb;
   logic         h_ov, v_ov, proc_c, blk_c, cactus_c, coin_hit;
   logic [3:0]   touch_c, edge_c;    // {up, right, down, left}

   assign cx = W'(cx_q);
   assign cy = W'(cy_q);
   assign cr = cx + CHR_W;
   assign cb = cy + CHR_H;
   assign tx = W'(tap_col) * BLK_W;
   assign ty = W'(tap_row) * BLK_W;
   assign tr = tx + BLK_W;
   assign tb = ty + BLK_W;

   assign h_ov     = (cx < tr) && (tx < cr);
   assign v_ov     = (cy < tb) && (ty < cb);
   assign proc_c   = tap_v && busy_c && play_state;
   assign blk_c    = proc_c && (blk_type == T_BLOCK);
   assign cactus_c = proc_c && (blk_type == T_CACTUS) && h_ov && v_ov;
   assign coin_hit = proc_c && (blk_type == T_COIN) && h_ov && v_ov;

   assign touch_c = {(cy == tb) && h_ov, (cr == tx) && v_ov,
                     (cb == ty) && h_ov, (cx == tr) && v_ov};
   assign edge_c  = {cy == '0, cr == SCN_W, cb == SCN_H, cx == '0};

   // ------------------------------------------------------------ results
   logic [3:0] sh_q, obs_q;
   logic       reach_q, die_q, done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_q    <= '0;
         obs_q   <= '0;
         reach_q <= 1'b0;
         die_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= publish_c;
         if (accept_c)   sh_q <= '0;
         else if (blk_c) sh_q <= sh_q | touch_c;
         if (publish_c) begin
            obs_q   <= sh_q | edge_c;
            reach_q <= (cx + HALF_W) >= SCN_W;
         end
         if (cactus_c) die_q <= 1'b1;
      end
   end

   assign {obs_up, obs_right, obs_down, obs_left} = obs_q;
   assign reach_end = reach_q;
   assign die       = die_q;
   assign done      = done_q;

   // ------------------------------------------------------- pending coins
   logic coin_push, coin_pop;

`ifdef COIN_FIFO_EN
   logic [ADDR_W-1:0] fifo_mem [4];
   logic [1:0]        rd_q, wr_q;
   logic [2:0]        cnt_q;
   logic              dup_c;

   always_comb begin
      dup_c = 1'b0;
      for (int i = 0; i < 4; i++)
         if ((3'(i) < cnt_q) && (fifo_mem[rd_q + 2'(i)] == tap_addr)) dup_c = 1'b1;
   end

   assign coin_push = coin_hit && (cnt_q != 3'd4) && !dup_c;
   assign coin_pop  = coin_ack && (cnt_q != 3'd0);

   // NOTE: the storage array has no reset; occupancy is tracked by cnt_q, so stale
   // entries are never visible and the array can map onto plain flops or RAM.
   always_ff @(posedge clk) begin
      if (coin_push) fifo_mem[wr_q] <= tap_addr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (coin_push) wr_q <= wr_q + 2'd1;
         if (coin_pop)  rd_q <= rd_q + 2'd1;
         cnt_q <= cnt_q + 3'(coin_push) - 3'(coin_pop);
      end
   end

   assign coin_valid = (cnt_q != 3'd0);
   assign coin_addr  = coin_valid ? fifo_mem[rd_q] : '0;
`else
   logic              pend_v_q;
   logic [ADDR_W-1:0] pend_addr_q;

   assign coin_push = coin_hit && !pend_v_q;
   assign coin_pop  = coin_ack && pend_v_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         pend_v_q <= coin_push || (pend_v_q && !coin_pop);
         if (coin_push) pend_addr_q <= tap_addr;
      end
   end

   assign coin_valid = pend_v_q;
   assign coin_addr  = pend_v_q ? pend_addr_q : '0;
`endif

   // Two-digit BCD counter, wraps 99 -> 00.
   logic [7:0] score_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         score_q <= '0;
      end else if (coin_push) begin
         if (score_q[3:0] == 4'd9) begin
            score_q[3:0] <= 4'd0;
            score_q[7:4] <= (score_q[7:4] == 4'd9) ? 4'd0 : score_q[7:4] + 4'd1;
         end else begin
            score_q[3:0] <= score_q[3:0] + 4'd1;
         end
      end
   end

   assign score = score_q;

endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed scans of a modelled scene memory; a pixel-rectangle model
// predicts results and a compare process checks the idle-time outputs every cycle.
module tb_collision_scanner;

   localparam int SW = 20, SH = 15, BLK = 20, CHW = 20, CHH = 40, LAT = 1;
   localparam int SCAN_CYC = SW * SH + LAT + 1;
`ifdef COIN_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst, play_state, start, coin_ack;
   logic [8:0] char_x, char_y, blk_addr, coin_addr;
   logic [1:0] blk_type;
   logic       busy, done, obs_up, obs_right, obs_down, obs_left;
   logic       die, reach_end, coin_valid;
   logic [7:0] score;

   logic [1:0] scene [512];

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // model state
   int m_up, m_right, m_down, m_left, m_reach, m_die, m_score;
   int m_q[$];

   collision_scanner dut (
      .clk(clk), .rst(rst), .play_state(play_state), .start(start),
      .char_x(char_x), .char_y(char_y), .blk_type(blk_type), .blk_addr(blk_addr),
      .busy(busy), .done(done), .obs_up(obs_up), .obs_right(obs_right),
      .obs_down(obs_down), .obs_left(obs_left), .die(die), .reach_end(reach_end),
      .score(score), .coin_valid(coin_valid), .coin_addr(coin_addr), .coin_ack(coin_ack)
   );

   always #5 clk = ~clk;

   // one-cycle-latency scene memory
   always @(posedge clk) blk_type <= scene[blk_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bcd(input int v);
      return (v / 10) * 16 + (v % 10);
   endfunction

   function automatic bit pending(input int a);
      foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_up = 0; m_right = 0; m_down = 0; m_left = 0;
      m_reach = 0; m_die = 0; m_score = 0;
      m_q.delete();
   endtask

   task automatic model_scan(input int x, input int y);
      int up, rt, dn, lf, tx, ty, a;
      bit hov, vov;
      up = 0; rt = 0; dn = 0; lf = 0;
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            tx  = c * BLK;
            ty  = r * BLK;
            a   = r * SW + c;
            hov = (x < tx + BLK) && (tx < x + CHW);
            vov = (y < ty + BLK) && (ty < y + CHH);
            case (scene[a])
               2'd1: begin
                  if (hov && y == ty + BLK) up = 1;
                  if (hov && y + CHH == ty) dn = 1;
                  if (vov && x == tx + BLK) lf = 1;
                  if (vov && x + CHW == tx) rt = 1;
               end
               2'd2: if (hov && vov) m_die = 1;
               2'd3: if (hov && vov && !pending(a) && m_q.size() < CAP) begin
                  m_q.push_back(a);
                  m_score = (m_score + 1) % 100;
               end
               default: ;
            endcase
         end
      end
      if (y == 0) up = 1;
      if (y + CHH == SH * BLK) dn = 1;
      if (x == 0) lf = 1;
      if (x + CHW == SW * BLK) rt = 1;
      m_up = up; m_right = rt; m_down = dn; m_left = lf;
      m_reach = (x + CHW / 2 >= SW * BLK) ? 1 : 0;
   endtask

   // compare process: checks all held outputs whenever no scan is in flight
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", busy, 0);
         check("obs_up", obs_up, m_up);
         check("obs_right", obs_right, m_right);
         check("obs_down", obs_down, m_down);
         check("obs_left", obs_left, m_left);
         check("reach_end", reach_end, m_reach);
         check("die", die, m_die);
         check("score", score, bcd(m_score));
         check("coin_valid", coin_valid, (m_q.size() != 0) ? 1 : 0);
         check("coin_addr", coin_addr, (m_q.size() != 0) ? m_q[0] : 0);
      end
   end

   task automatic clear_scene();
      foreach (scene[i]) scene[i] = 2'd0;
   endtask

   task automatic run_scan(input int x, input int y, input bit disturb);
      int lat;
      lat = -1;
      cmp_en = 1'b0;
      @(negedge clk);
      char_x = 9'(x);
      char_y = 9'(y);
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= SCAN_CYC + 50; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) check("busy_in_scan", busy, 1);
         if (disturb && k == 150) begin
            start  = 1'b1;
            char_x = 9'd0;
            char_y = 9'd0;
         end
         if (disturb && k == 151) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      check("done_latency", lat, SCAN_CYC);
      @(posedge clk);
      #1 check("done_pulse_len", done, 0);
      model_scan(x, y);
      cmp_en = 1'b1;
   endtask

   task automatic do_ack();
      @(negedge clk);
      coin_ack = 1'b1;
      @(posedge clk);
      #1 coin_ack = 1'b0;
      if (m_q.size() != 0) m_q.delete(0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_blk_addr"}, blk_addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_obs"}, {obs_up, obs_right, obs_down, obs_left}, 0);
      check({tag, "_reach"}, reach_end, 0);
      check({tag, "_die"}, die, 0);
      check({tag, "_score"}, score, 0);
      check({tag, "_coin_valid"}, coin_valid, 0);
      check({tag, "_coin_addr"}, coin_addr, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops;
      int exp_addrs[3];
      bit seen;
      exp_addrs = '{43, 63, 83};
      clear_scene();
      model_reset();
      rst = 1'b0; play_state = 1'b1; start = 1'b0; coin_ack = 1'b0;
      char_x = '0; char_y = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;

      // block below the character plus a corner-only neighbour; mid-scan disturbance
      scene[10*SW+5] = 2'd1;
      scene[10*SW+6] = 2'd1;
      run_scan(100, 160, 1'b1);
      check("t1_down", obs_down, 1);
      check("t1_others", {obs_up, obs_right, obs_left}, 0);

      clear_scene();
      scene[9*SW+6] = 2'd1;
      scene[8*SW+4] = 2'd1;
      scene[7*SW+5] = 2'd1;
      run_scan(100, 160, 1'b0);
      check("t2_up_right_left", {obs_up, obs_right, obs_down, obs_left}, 4'b1101);

      clear_scene();
      run_scan(0, 0, 1'b0);
      check("t3_corner00", {obs_up, obs_right, obs_down, obs_left}, 4'b1001);
      run_scan(380, 0, 1'b0);
      check("t3_right_edge", obs_right, 1);
      run_scan(390, 260, 1'b0);
      check("t3_reach_end", reach_end, 1);
      check("t3_bottom_edge", obs_down, 1);

      clear_scene();
      scene[3*SW+3] = 2'd2;
      run_scan(60, 50, 1'b0);
      check("t4_die", die, 1);
      clear_scene();
      run_scan(200, 100, 1'b0);
      check("t4_die_sticky", die, 1);

      clear_scene();
      scene[63] = 2'd3;
      repeat (9) begin
         run_scan(60, 50, 1'b0);
         do_ack();
      end
      check("t5_score09", score, 8'h09);
      run_scan(60, 50, 1'b0);
      check("t5_score10", score, 8'h10);
      check("t5_coin_valid", coin_valid, 1);
      check("t5_coin_addr", coin_addr, 63);
      do_ack();
      @(negedge clk);
      check("t5_popped", coin_valid, 0);
      do_ack();

      clear_scene();
      scene[43] = 2'd3;
      scene[63] = 2'd3;
      scene[83] = 2'd3;
      run_scan(60, 50, 1'b0);
      check("t6_score", score, (CAP == 4) ? 8'h13 : 8'h11);
      run_scan(60, 50, 1'b0);
      check("t6_rescan_score", score, (CAP == 4) ? 8'h13 : 8'h11);
      pops = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!coin_valid) break;
         if (i < 3) check("t6_pop_addr", coin_addr, exp_addrs[i]);
         do_ack();
         pops++;
      end
      check("t6_pops", pops, (CAP == 4) ? 3 : 1);

      // abort a scan by dropping play_state
      clear_scene();
      cmp_en = 1'b0;
      @(negedge clk);
      char_x = 9'd0; char_y = 9'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk);
      play_state = 1'b0;
      @(posedge clk);
      #1 check("abort_idle", busy, 0);
      cmp_en = 1'b1;
      seen = 1'b0;
      repeat (320) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      check("abort_obs_held", {obs_up, obs_left}, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("start_ignored_paused", busy, 0);
      play_state = 1'b1;

      // reset in the middle of a scan with state to clear
      scene[43] = 2'd3;
      run_scan(60, 50, 1'b0);
      cmp_en = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check_reset_vals("midscan_rst");
      model_reset();
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      clear_scene();
      scene[10*SW+5] = 2'd1;
      run_scan(100, 160, 1'b0);
      check("post_rst_down", obs_down, 1);
      check("post_rst_die", die, 0);

      cmp_en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
